load_data_unit: RTL and testbench
=================================

LOAD_DATA_UNIT -- requirements
Module: load_data_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter TIMEOUT_CYCLES, default 255, SHALL set the maximum WAIT cycles before bus error (8-bit counter).
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 ld_valid  in  1  load issued this cycle.
REQ-006 ld_op  in  8  EXE_LW_OP/EXE_LH_OP/EXE_LHU_OP/EXE_LB_OP/EXE_LBU_OP codes from defines.vh; any other code SHALL be ignored.
REQ-007 ld_addr  in  32  byte address.
REQ-008 flush  in  1  abandon the in-flight load.
REQ-009 mem_req  out  1  one-cycle read request pulse.
REQ-010 mem_addr  out  32  word address {addr[31:2],2'b00}, held from REQ through WAIT.
REQ-011 mem_rdata  in  32; mem_rvalid  in  1  read response, valid for one cycle.
REQ-012 stall  out  1  hold the pipeline.
REQ-013 ld_done  out  1; ld_data  out  32  one-cycle result strobe and aligned, extended data.
REQ-014 adel  out  1; badvaddr  out  32  misaligned-load exception pulse and offending address.
REQ-015 bus_err  out  1  timeout pulse.

Function
REQ-016 States SHALL be IDLE, REQ, WAIT, DONE, DRAIN.
REQ-017 In IDLE, ld_valid with a legal op and aligned address SHALL capture op, addr[1:0] and mem_addr, then go to REQ.
REQ-018 REQ SHALL assert mem_req for exactly one cycle, then go to WAIT.
REQ-019 In WAIT, mem_rvalid SHALL capture the processed data into ld_data and go to DONE.
REQ-020 DONE SHALL assert ld_done for exactly one cycle, then return to IDLE; ld_data SHALL hold until the next capture.
REQ-021 Minimum latency ld_valid -> ld_done SHALL be 3 cycles, when mem_rvalid arrives in the first WAIT cycle.
REQ-022 stall SHALL be 1 when (IDLE and a load is accepted), in REQ, in WAIT, or in DRAIN with ld_valid=1; it SHALL be 0 otherwise.
REQ-023 Byte lanes are little-endian: offset 00 -> [7:0], 01 -> [15:8], 10 -> [23:16], 11 -> [31:24].
REQ-024 LB/LBU SHALL sign-/zero-extend the selected byte.
REQ-025 LH/LHU SHALL sign-/zero-extend [15:0] at offset 00 and [31:16] at offset 10.
REQ-026 LW SHALL pass the word unchanged.
REQ-027 flush in REQ or WAIT SHALL go to DRAIN without ld_done.
REQ-028 flush coincident with mem_rvalid in WAIT SHALL discard the data and go to IDLE.
REQ-029 DRAIN SHALL discard the next mem_rvalid, then return to IDLE.
REQ-030 The WAIT counter SHALL clear on entering WAIT; reaching TIMEOUT_CYCLES without mem_rvalid SHALL pulse bus_err for one cycle and go to DRAIN.
REQ-031 flush in IDLE or DONE SHALL have no effect; ld_valid is ignored outside IDLE.

Reset
REQ-032 rst SHALL force state IDLE, counter 0, and all outputs (mem_req, mem_addr, stall, ld_done, ld_data, adel, badvaddr, bus_err) to 0.
REQ-033 rst mid-operation SHALL abandon the load with no ld_done; a later stray mem_rvalid in IDLE SHALL be ignored.

Configuration
REQ-034 With LOAD_ALIGN_CHECK_EN defined, LH/LHU with addr[0]=1 or LW with addr[1:0]!=00 SHALL pulse adel for one cycle, load badvaddr=ld_addr, issue no request, and stay in IDLE with stall=0.
REQ-035 Without LOAD_ALIGN_CHECK_EN, adel and badvaddr SHALL be tied to 0; LH/LHU SHALL use addr[1] only and LW SHALL ignore addr[1:0].

Verification
REQ-036 LB addr 0x1003, rdata 0x80FF_FF7F, rvalid in first WAIT cycle -> ld_done 3 cycles after ld_valid, ld_data 0xFFFF_FF80.
REQ-037 LHU addr 0x2002, rdata 0xBEEF_1234 -> ld_data 0x0000_BEEF; LH same -> 0xFFFF_BEEF; mem_addr 0x2000.
REQ-038 LW addr 0x3001 with LOAD_ALIGN_CHECK_EN -> adel=1, badvaddr 0x3001, mem_req never asserted; without the macro -> mem_addr 0x3000, normal completion.
REQ-039 LW issued, flush in the second WAIT cycle, rvalid two cycles later -> no ld_done, state IDLE after rvalid; a new load is stalled until then.
REQ-040 TIMEOUT_CYCLES=4, no rvalid -> bus_err single pulse after 4 WAIT cycles, DRAIN entered, no ld_done.

Source files
------------

// File: rtl/load_data_unit.sv
// Load unit: one word read per load, returned data aligned and extended; ld_valid->ld_done is 3 cycles minimum.
// stall holds the pipeline while a load is in flight. Misaligned-load exception is enabled by LOAD_ALIGN_CHECK_EN.
module load_data_unit #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ld_valid,
   input  logic [7:0]  ld_op,
   input  logic [31:0] ld_addr,
   input  logic        flush,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_rdata,
   input  logic        mem_rvalid,
   output logic        stall,
   output logic        ld_done,
   output logic [31:0] ld_data,
   output logic        adel,
   output logic [31:0] badvaddr,
   output logic        bus_err
);
   localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
   localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
   localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
   localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
   localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;

   typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, DRAIN} state_t;

   state_t      state, state_nxt;
   logic [7:0]  op_q;
   logic [1:0]  off_q;
   logic [7:0]  wait_cnt;
   logic        op_legal;
   logic        misaligned;
   logic        accept;
   logic        timeout;

   assign op_legal = (ld_op == EXE_LB_OP) || (ld_op == EXE_LBU_OP) || (ld_op == EXE_LH_OP) ||
                     (ld_op == EXE_LHU_OP) || (ld_op == EXE_LW_OP);

`ifdef LOAD_ALIGN_CHECK_EN
   assign misaligned = (((ld_op == EXE_LH_OP) || (ld_op == EXE_LHU_OP)) && ld_addr[0]) ||
                       ((ld_op == EXE_LW_OP) && (ld_addr[1:0] != 2'b00));
`else
   assign misaligned = 1'b0;
`endif

   assign accept  = (state == IDLE) && ld_valid && op_legal && !misaligned;
   assign timeout = (wait_cnt == 8'(TIMEOUT_CYCLES - 1));

   // Halfwords only look at offset bit 1; with the alignment check on, bit 0 is always clear here.
   function automatic logic [31:0] align_data(input logic [7:0] op, input logic [1:0] off,
                                              input logic [31:0] w);
      logic [7:0]  b;
      logic [15:0] h;
      case (off)
         2'b00:   b = w[7:0];
         2'b01:   b = w[15:8];
         2'b10:   b = w[23:16];
         default: b = w[31:24];
      endcase
      h = off[1] ? w[31:16] : w[15:0];
      case (op)
         EXE_LB_OP:  align_data = {{24{b[7]}}, b};
         EXE_LBU_OP: align_data = {24'd0, b};
         EXE_LH_OP:  align_data = {{16{h[15]}}, h};
         EXE_LHU_OP: align_data = {16'd0, h};
         default:    align_data = w;
      endcase
   endfunction

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (accept) state_nxt = REQ;
         REQ:   state_nxt = flush ? DRAIN : WAIT;
         WAIT: begin
            if (flush)           state_nxt = mem_rvalid ? IDLE : DRAIN;
            else if (mem_rvalid) state_nxt = DONE;
            else if (timeout)    state_nxt = DRAIN;
         end
         DONE:  state_nxt = IDLE;
         DRAIN: if (mem_rvalid) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign mem_req = !rst && (state == REQ);
   assign ld_done = !rst && (state == DONE);
   assign stall   = !rst && (accept || (state == REQ) || (state == WAIT) ||
                             ((state == DRAIN) && ld_valid));

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         op_q     <= 8'd0;
         off_q    <= 2'd0;
         mem_addr <= 32'd0;
         wait_cnt <= 8'd0;
         ld_data  <= 32'd0;
         bus_err  <= 1'b0;
      end else begin
         state   <= state_nxt;
         bus_err <= (state == WAIT) && !flush && !mem_rvalid && timeout;
         if (accept) begin
            op_q     <= ld_op;
            off_q    <= ld_addr[1:0];
            mem_addr <= {ld_addr[31:2], 2'b00};
         end
         wait_cnt <= (state == WAIT) ? wait_cnt + 8'd1 : 8'd0;
         if ((state == WAIT) && mem_rvalid && !flush)
            ld_data <= align_data(op_q, off_q, mem_rdata);
      end
   end

`ifdef LOAD_ALIGN_CHECK_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         adel     <= 1'b0;
         badvaddr <= 32'd0;
      end else begin
         adel <= (state == IDLE) && ld_valid && op_legal && misaligned;
         if ((state == IDLE) && ld_valid && op_legal && misaligned)
            badvaddr <= ld_addr;
      end
   end
`else
   assign adel     = 1'b0;
   assign badvaddr = 32'd0;
`endif

endmodule

// File: tb/tb_load_data_unit.sv
// Bench for load_data_unit: directed loads, expected ld_data queued at issue and checked by a monitor on ld_done.
module tb_load_data_unit;
   localparam logic [7:0] OP_LB  = 8'hE0;
   localparam logic [7:0] OP_LH  = 8'hE1;
   localparam logic [7:0] OP_LW  = 8'hE3;
   localparam logic [7:0] OP_LBU = 8'hE4;
   localparam logic [7:0] OP_LHU = 8'hE5;

   logic        clk = 1'b0;
   logic        rst, ld_valid, flush, mem_rvalid;
   logic [7:0]  ld_op;
   logic [31:0] ld_addr, mem_rdata;
   logic        mem_req, stall, ld_done, adel, bus_err;
   logic [31:0] mem_addr, ld_data, badvaddr;

   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          done_cnt = 0;
   int          done_cyc = -1;
   int          d0;
   logic [31:0] exp_q[$];
   logic [31:0] exp_v;
   logic [31:0] last_exp = 32'd0;

   load_data_unit #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_op(ld_op), .ld_addr(ld_addr),
      .flush(flush), .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .mem_rvalid(mem_rvalid), .stall(stall), .ld_done(ld_done), .ld_data(ld_data),
      .adel(adel), .badvaddr(badvaddr), .bus_err(bus_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every ld_done must match the oldest queued expectation.
   always @(negedge clk) begin
      if (!rst && ld_done) begin
         done_cnt++;
         done_cyc = cyc;
         chk("ld_done_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            exp_v = exp_q.pop_front();
            chk("ld_data", ld_data, exp_v);
         end
      end
   end

   task automatic do_load(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] rdata,
                          input logic [31:0] exp, input logic [31:0] waddr, input int delay,
                          input string nm);
      int start;
      ld_valid = 1'b1; ld_op = op; ld_addr = addr;
      exp_q.push_back(exp);
      last_exp = exp;
      start = cyc;
      #1 chk({nm, "_stall_accept"}, 32'(stall), 32'd1);
      step();
      ld_valid = 1'b0;
      chk({nm, "_mem_req"}, 32'(mem_req), 32'd1);
      chk({nm, "_mem_addr"}, mem_addr, waddr);
      step();
      chk({nm, "_mem_req_pulse"}, 32'(mem_req), 32'd0);
      repeat (delay) begin
         chk({nm, "_stall_wait"}, 32'(stall), 32'd1);
         step();
      end
      mem_rvalid = 1'b1; mem_rdata = rdata;
      step();
      mem_rvalid = 1'b0; mem_rdata = 32'hXXXX_XXXX;
      chk({nm, "_stall_done"}, 32'(stall), 32'd0);
      step();
      chk({nm, "_latency"}, 32'(done_cyc - start), 32'(3 + delay));
      chk({nm, "_done_pulse"}, 32'(ld_done), 32'd0);
   endtask

   initial begin
      rst = 1'b1; ld_valid = 1'b1; ld_op = OP_LW; ld_addr = 32'h0; flush = 1'b0;
      mem_rvalid = 1'b0; mem_rdata = 32'h0;
      step(); step();
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_ld_done", 32'(ld_done), 32'd0);
      chk("rst_ld_data", ld_data, 32'd0);
      chk("rst_adel", 32'(adel), 32'd0);
      chk("rst_badvaddr", badvaddr, 32'd0);
      chk("rst_bus_err", 32'(bus_err), 32'd0);
      ld_valid = 1'b0; rst = 1'b0;
      step();

      do_load(OP_LB,  32'h1003, 32'h80FF_FF7F, 32'hFFFF_FF80, 32'h1000, 0, "lb_3");
      do_load(OP_LHU, 32'h2002, 32'hBEEF_1234, 32'h0000_BEEF, 32'h2000, 0, "lhu_2");
      do_load(OP_LH,  32'h2002, 32'hBEEF_1234, 32'hFFFF_BEEF, 32'h2000, 1, "lh_2");
      do_load(OP_LH,  32'h2000, 32'hBEEF_8234, 32'hFFFF_8234, 32'h2000, 0, "lh_0");
      do_load(OP_LBU, 32'h1001, 32'h80FF_FF7F, 32'h0000_00FF, 32'h1000, 0, "lbu_1");
      do_load(OP_LB,  32'h1000, 32'h80FF_FF7F, 32'h0000_007F, 32'h1000, 0, "lb_0");
      do_load(OP_LBU, 32'h1002, 32'h1234_5678, 32'h0000_0034, 32'h1000, 0, "lbu_2");
      do_load(OP_LW,  32'h4000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h4000, 2, "lw_0");

      // Illegal op code is ignored.
      ld_valid = 1'b1; ld_op = 8'h00; ld_addr = 32'h5000;
      #1 chk("illegal_stall", 32'(stall), 32'd0);
      step();
      ld_valid = 1'b0;
      chk("illegal_mem_req", 32'(mem_req), 32'd0);

`ifdef LOAD_ALIGN_CHECK_EN
      d0 = done_cnt;
      ld_valid = 1'b1; ld_op = OP_LW; ld_addr = 32'h3001;
      #1 chk("lw_mis_stall", 32'(stall), 32'd0);
      step();
      ld_valid = 1'b0;
      chk("lw_mis_adel", 32'(adel), 32'd1);
      chk("lw_mis_badvaddr", badvaddr, 32'h3001);
      chk("lw_mis_mem_req", 32'(mem_req), 32'd0);
      step();
      chk("lw_mis_adel_pulse", 32'(adel), 32'd0);
      chk("lw_mis_mem_req2", 32'(mem_req), 32'd0);
      ld_valid = 1'b1; ld_op = OP_LHU; ld_addr = 32'h2003;
      #1 chk("lh_mis_stall", 32'(stall), 32'd0);
      step();
      ld_valid = 1'b0;
      chk("lh_mis_adel", 32'(adel), 32'd1);
      chk("lh_mis_badvaddr", badvaddr, 32'h2003);
      chk("lh_mis_mem_req", 32'(mem_req), 32'd0);
      step();
      chk("mis_no_done", 32'(done_cnt), 32'(d0));
`else
      do_load(OP_LW,  32'h3001, 32'h1122_3344, 32'h1122_3344, 32'h3000, 0, "lw_1");
      chk("lw_1_adel", 32'(adel), 32'd0);
      chk("lw_1_badvaddr", badvaddr, 32'd0);
      do_load(OP_LHU, 32'h2003, 32'hBEEF_1234, 32'h0000_BEEF, 32'h2000, 0, "lhu_3");
`endif

      // Flush in the second WAIT cycle; response arrives two cycles later.
      d0 = done_cnt;
      ld_valid = 1'b1; ld_op = OP_LW; ld_addr = 32'h5000;
      step();
      ld_valid = 1'b0;
      step();
      step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      ld_valid = 1'b1; ld_op = OP_LW; ld_addr = 32'h6000;
      #1 chk("drain_stall_new", 32'(stall), 32'd1);
      chk("drain_mem_req", 32'(mem_req), 32'd0);
      step();
      mem_rvalid = 1'b1; mem_rdata = 32'hAAAA_5555;
      #1 chk("drain_stall_rvalid", 32'(stall), 32'd1);
      step();
      mem_rvalid = 1'b0; ld_valid = 1'b0;
      #1 chk("drain_idle_stall", 32'(stall), 32'd0);
      chk("drain_no_done", 32'(done_cnt), 32'(d0));
      chk("drain_data_held", ld_data, last_exp);
      do_load(OP_LW, 32'h6000, 32'h0BAD_F00D, 32'h0BAD_F00D, 32'h6000, 0, "lw_after_drain");

      // Flush in REQ, then drain the response.
      d0 = done_cnt;
      ld_valid = 1'b1; ld_op = OP_LB; ld_addr = 32'h1000;
      step();
      ld_valid = 1'b0; flush = 1'b1;
      step();
      flush = 1'b0;
      chk("flreq_mem_req", 32'(mem_req), 32'd0);
      chk("flreq_stall", 32'(stall), 32'd0);
      mem_rvalid = 1'b1; mem_rdata = 32'h0000_0011;
      step();
      mem_rvalid = 1'b0;
      step();
      chk("flreq_no_done", 32'(done_cnt), 32'(d0));

      // Flush coincident with the response goes straight back to IDLE.
      ld_valid = 1'b1; ld_op = OP_LW; ld_addr = 32'h7700;
      step();
      ld_valid = 1'b0;
      step();
      flush = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1357_9BDF;
      step();
      flush = 1'b0; mem_rvalid = 1'b0;
      chk("flrv_stall", 32'(stall), 32'd0);
      chk("flrv_data_held", ld_data, last_exp);
      do_load(OP_LHU, 32'h7702, 32'h4321_8765, 32'h0000_4321, 32'h7700, 0, "lhu_after_flrv");
      chk("flrv_no_done", 32'(done_cnt), 32'(d0 + 1));

      // Timeout after 4 WAIT cycles.
      d0 = done_cnt;
      ld_valid = 1'b1; ld_op = OP_LW; ld_addr = 32'h7000;
      step();
      ld_valid = 1'b0;
      step();
      for (int i = 0; i < 4; i++) begin
         chk("to_bus_err_early", 32'(bus_err), 32'd0);
         step();
      end
      chk("to_bus_err", 32'(bus_err), 32'd1);
      chk("to_drain_stall", 32'(stall), 32'd0);
      step();
      chk("to_bus_err_pulse", 32'(bus_err), 32'd0);
      mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_0000;
      step();
      mem_rvalid = 1'b0;
      step();
      chk("to_no_done", 32'(done_cnt), 32'(d0));

      // Reset mid-load, then a stray response.
      d0 = done_cnt;
      ld_valid = 1'b1; ld_op = OP_LW; ld_addr = 32'h8000;
      step();
      ld_valid = 1'b0;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("midrst_stall", 32'(stall), 32'd0);
      chk("midrst_ld_data", ld_data, 32'd0);
      chk("midrst_mem_addr", mem_addr, 32'd0);
      mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
      step();
      mem_rvalid = 1'b0;
      step();
      step();
      chk("midrst_no_done", 32'(done_cnt), 32'(d0));
      chk("midrst_stray_mem_req", 32'(mem_req), 32'd0);
      do_load(OP_LB, 32'h9001, 32'h0000_8000, 32'hFFFF_FF80, 32'h9000, 0, "lb_after_rst");

      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
